// File: rtl/nibble_add_pkg.sv
// Shared definitions for the nibble-serial adder: nibble width, FSM states and
// the nibble-count helper.

package nibble_add_pkg;

   localparam int unsigned NIB_W = 4;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   function automatic int unsigned nib_count(input int unsigned width);
      return width / NIB_W;
   endfunction

endpackage

// File: rtl/nibble_add4.sv
// Combinational 4-bit ripple-carry full-adder stage; the only adder in the
// serial datapath.

module nibble_add4
   import nibble_add_pkg::*;
(
   input  logic [NIB_W-1:0] x,
   input  logic [NIB_W-1:0] y,
   input  logic             ci,
   output logic [NIB_W-1:0] s,
   output logic             co
);

   logic [NIB_W:0] c;

   always_comb begin
      c    = '0;
      s    = '0;
      c[0] = ci;
      for (int i = 0; i < NIB_W; i++) begin
         s[i]   = x[i] ^ y[i] ^ c[i];
         c[i+1] = (x[i] & y[i]) | (x[i] & c[i]) | (y[i] & c[i]);
      end
      co = c[NIB_W];
   end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one nibble per clock through a shared 4-bit stage.
// Define NIBBLE_SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.

module nibble_serial_adder
   import nibble_add_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int unsigned NIB   = nib_count(WIDTH);
   localparam int unsigned IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] part_q, part_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             done_q, done_d;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   logic [NIB_W-1:0] nib_x, nib_y, nib_s;
   logic             nib_co;

   // Operand nibble selected by the running index feeds the single adder stage.
   assign nib_x = a_q[idx_q*NIB_W +: NIB_W];
   assign nib_y = b_q[idx_q*NIB_W +: NIB_W];

   nibble_add4 u_add4 (
      .x  (nib_x),
      .y  (nib_y),
      .ci (carry_q),
      .s  (nib_s),
      .co (nib_co)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      part_d  = part_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      done_d  = 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      ovf_d   = ovf_q;
`endif

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_RUN;
               a_d     = a;
               b_d     = b;
               carry_d = cin;
               idx_d   = '0;
            end
         end
         ST_RUN: begin
            part_d[idx_q*NIB_W +: NIB_W] = nib_s;
            carry_d = nib_co;
            idx_d   = idx_q + 1'b1;
            if (idx_q == IDX_LAST) begin
               state_d = ST_IDLE;
               idx_d   = '0;
               sum_d   = part_d;
               cout_d  = nib_co;
               done_d  = 1'b1;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
               // Carry into the MSB is recovered from its sum bit.
               ovf_d   = nib_co ^ (nib_s[NIB_W-1] ^ nib_x[NIB_W-1] ^ nib_y[NIB_W-1]);
`endif
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         part_q  <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         part_q  <= part_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         done_q  <= done_d;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign busy = (state_q == ST_RUN);
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
   assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=16): directed cases plus
// random operands compared against plain-arithmetic expectations.

module tb_nibble_serial_adder;

   localparam int unsigned WIDTH = 16;
   localparam int unsigned NIB   = WIDTH / 4;

   logic             clk;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
   logic             ovf;
`endif

   int unsigned n_checks;
   int unsigned n_err;
   int unsigned n_vec;

   logic [WIDTH-1:0] exp_sum;
   logic             exp_cout;
   logic             exp_ovf;

   nibble_serial_adder #(
      .WIDTH (WIDTH)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic chk_outputs(input string tag);
      chk({tag, "_sum"}, 32'(sum), 32'(exp_sum));
      chk({tag, "_cout"}, 32'(cout), 32'(exp_cout));
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      chk({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
`endif
   endtask

   // Launches one addition and follows it to its done cycle; returns in the done cycle.
   task automatic do_add(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                         input logic ci, input bit noise, input int pulse_at);
      logic [WIDTH:0] full;
      full  = {1'b0, av} + {1'b0, bv} + (WIDTH+1)'(ci);
      start = 1'b1;
      a     = av;
      b     = bv;
      cin   = ci;
      tick();
      start = 1'b0;
      chk("busy_after_start", 32'(busy), 32'd1);
      for (int k = 1; k <= int'(NIB); k++) begin
         if (noise) begin
            a     = WIDTH'($urandom);
            b     = WIDTH'($urandom);
            cin   = 1'($urandom_range(0, 1));
            start = 1'($urandom_range(0, 1));
         end
         if (k == pulse_at) begin
            start = 1'b1;
            a     = 16'h0001;
            b     = 16'h0001;
            cin   = 1'b0;
         end
         tick();
         start = 1'b0;
         if (k < int'(NIB)) begin
            chk("busy_in_run", 32'(busy), 32'd1);
            chk("done_in_run", 32'(done), 32'd0);
            chk_outputs("hold_in_run");
         end
      end
      n_vec++;
      exp_sum  = full[WIDTH-1:0];
      exp_cout = full[WIDTH];
      exp_ovf  = (av[WIDTH-1] == bv[WIDTH-1]) && (exp_sum[WIDTH-1] != av[WIDTH-1]);
      chk("done_pulse", 32'(done), 32'd1);
      chk("busy_at_done", 32'(busy), 32'd0);
      chk_outputs("result");
   endtask

   initial begin
      n_checks = 0;
      n_err    = 0;
      n_vec    = 0;
      rst      = 1'b1;
      start    = 1'b0;
      a        = '0;
      b        = '0;
      cin      = 1'b0;
      exp_sum  = '0;
      exp_cout = 1'b0;
      exp_ovf  = 1'b0;

      tick();
      tick();
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk_outputs("reset");
      rst = 1'b0;
      tick();

      do_add(16'h1234, 16'h4321, 1'b0, 1'b0, 0);
      tick();
      chk("done_clears", 32'(done), 32'd0);
      chk_outputs("held_after_done");

      do_add(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
      tick();
      do_add(16'hFFFF, 16'h0000, 1'b1, 1'b0, 0);
      tick();

      // Start pulse during a run must be ignored; no second done may follow.
      do_add(16'h00F0, 16'h0010, 1'b0, 1'b0, 2);
      for (int i = 0; i < int'(NIB) + 2; i++) begin
         tick();
         chk("no_second_done", 32'(done), 32'd0);
         chk("idle_after_ignored", 32'(busy), 32'd0);
         chk_outputs("held_after_ignored");
      end

      // Back-to-back: the second start is driven in the first done cycle.
      do_add(16'h0010, 16'h0020, 1'b0, 1'b0, 0);
      do_add(16'h0002, 16'h0003, 1'b0, 1'b0, 0);
      tick();

      do_add(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
      do_add(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
      do_add(16'h8000, 16'h8000, 1'b0, 1'b0, 0);
      tick();

      // Reset in the middle of a run aborts it.
      start = 1'b1;
      a     = 16'hABCD;
      b     = 16'h1111;
      cin   = 1'b1;
      tick();
      start = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst      = 1'b0;
      exp_sum  = '0;
      exp_cout = 1'b0;
      exp_ovf  = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk_outputs("abort");
      for (int i = 0; i < int'(NIB) + 2; i++) begin
         tick();
         chk("abort_no_done", 32'(done), 32'd0);
         chk_outputs("abort_hold");
      end

      for (int i = 0; i < 40; i++) begin
         do_add(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)), 1'b1, 0);
         if ($urandom_range(0, 2) == 0) begin
            tick();
            chk("rand_idle_done", 32'(done), 32'd0);
            chk_outputs("rand_idle_hold");
         end
      end
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-cycle adder for wide operands. Adds two WIDTH-bit values 4 bits per clock using one combinational 4-bit full-adder stage, with a registered carry between nibbles.
- Sits between operand registers and result consumers in the datapath.
- Trades latency for area against a flat WIDTH-bit ripple chain.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be a multiple of 4 and at least 8. NIB = WIDTH/4 is the number of nibble steps.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when idle.
- a  input  WIDTH  operand A; captured on accepted start.
- b  input  WIDTH  operand B; captured on accepted start.
- cin  input  1  carry into nibble 0; captured on accepted start.
- busy  output  1  high while an addition is in progress.
- done  output  1  one-cycle pulse; sum/cout are newly valid.
- sum  output  WIDTH  registered result; holds until the next done.
- cout  output  1  registered carry out of the MSB nibble; holds with sum.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, nibble index=0, carry reg=0, operand regs=0, busy=0, done=0, sum=0, cout=0. Reset has priority over everything else.
- FSM states:
  - IDLE: busy=0. If start=1 at edge E, latch a, b, cin (cin goes into the carry reg), set index=0, go to RUN. Otherwise stay.
  - RUN: busy=1. Each edge adds nibble[index] of A, nibble[index] of B and the carry reg. The 4-bit sum is written into the partial-result reg at bits [4*index+3:4*index]. The nibble carry-out is written to the carry reg. index increments.
  - RUN exit: on the edge that processes index=NIB-1, the full result is copied to sum, the final carry goes to cout, done goes to 1, and the FSM returns to IDLE.
- Latency: start accepted at edge E; done=1 during the cycle after edge E+NIB. For WIDTH=16 that is edge E+4. Throughput: one result per NIB+1 edges.
- done: registered, high for exactly one cycle, cleared on the following edge.
- sum/cout update only on the done edge. No intermediate values are visible on these ports.
- start while busy=1 is ignored, with no queueing. Operand changes while busy have no effect.
- start=1 in the cycle where done=1 (state is IDLE) is accepted, giving back-to-back operation.
- rst asserted mid-RUN: operation aborted, no done pulse, all outputs return to reset values.
- Arithmetic is unsigned modulo 2^WIDTH, with carry out in cout. Each nibble stage computes s = x^y^c and co = majority(x,y,c) per bit, rippled across 4 bits.

Optional Feature:
- Macro: NIBBLE_SERIAL_ADDER_OVF_EN.
- When defined:
  - Adds output port ovf (1 bit), registered and updated only on the done edge.
  - ovf = carry into MSB XOR carry out of MSB, i.e. two's-complement signed overflow.
  - Reset value 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package nibble_add_pkg holds:
  - NIB_W = 4;
  - FSM state enum {ST_IDLE, ST_RUN};
  - a function computing the nibble count from WIDTH.
- One combinational sub-module, nibble_add4: inputs x[3:0], y[3:0], ci; outputs s[3:0], co. Instantiated once and muxed by index.
- The top level holds the FSM, index counter, carry reg, operand regs and result regs.

Test Plan (WIDTH=16):
- Start with a=0x1234, b=0x4321, cin=0 at edge E -> busy=1 for edges E+1..E+4; done=1 after edge E+4 with sum=0x5555, cout=0; sum unchanged before that edge.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1. Then a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1, with full carry propagation through all 4 nibbles.
- start pulsed again at edge E+2 with a=0x0001, b=0x0001 during a run of 0x00F0+0x0010 -> ignored; done once with sum=0x0100; no second done.
- Back-to-back: second start (0x0002+0x0003) asserted in the done cycle of the first -> second done exactly 5 edges after the first, sum=0x0005.
- rst=1 at edge E+2 of a run -> busy=0, done=0, sum=0, cout=0 after that edge; no done pulse follows.
- With NIBBLE_SERIAL_ADDER_OVF_EN: 0x7FFF+0x0001 -> sum=0x8000, cout=0, ovf=1. 0xFFFF+0x0001 -> ovf=0, cout=1.
